// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
// Shared types for the execute stage: data/address/instruction words, the ALU
// operation encoding, branch funct3 encodings, forwarding-select encodings and
// the multiply FSM state type. Also hosts the forwarding mux helper.
// -----------------------------------------------------------------------------
package execute_stage_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_t;

  // Branch condition encodings carried in funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Forwarding source selects; 2'b11 falls back to the register value
  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  // Pick an operand from the register file or one of the bypass paths
  function automatic data_t fwdSelect(input logic [1:0] sel, input data_t regVal,
                                      input data_t wbVal, input data_t memVal);
    data_t v;
    case (sel)
      FWD_WB:  v = wbVal;
      FWD_MEM: v = memVal;
      default: v = regVal;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// ex_to_mem_if
// EX/MEM pipeline register bundle. The Execute modport drives the fields,
// the Memory modport consumes them.
//   RegWrite   - destination register write enable
//   ResultSrc  - writeback result select
//   rd         - destination register index
//   alu_result - ALU (or multiply) result
//   funct3     - funct3 passed through for load/store sizing
// -----------------------------------------------------------------------------
interface ex_to_mem_if;
  import execute_stage_pkg::*;

  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [4:0] rd;
  data_t      alu_result;
  logic [2:0] funct3;

  modport Execute (output RegWrite, ResultSrc, rd, alu_result, funct3);
  modport Memory  (input  RegWrite, ResultSrc, rd, alu_result, funct3);
endinterface

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU. Arithmetic wraps modulo 2^32, shifts use
// b[4:0]. MUL is not handled here and yields 0.
//   a, b   - operands
//   op     - operation select (alu_op_t)
//   result - 32-bit result
// -----------------------------------------------------------------------------
module alu
  import execute_stage_pkg::*;
(
  input  data_t   a,
  input  data_t   b,
  input  alu_op_t op,
  output data_t   result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation decode
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = data_t'($signed(a) >>> shamt);
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// EX stage of a 5-stage RV32 pipeline: operand forwarding, ALU, branch
// resolution, jump target generation and the EX/MEM pipeline register.
//
// Optional feature macro: RV32M_MUL_EN
//   defined   - ALU_MUL runs a two-cycle IDLE/BUSY multiply; ex_busy stalls
//               ID/EX for one cycle while operands are captured.
//   undefined - no multiplier, ex_busy is 0, MUL returns 0 in one cycle.
//
// Ports
//   clk, reset            - clock, synchronous active-high reset
//   id_valid              - ID/EX holds a live instruction
//   pc, rs1_data, rs2_data, imm, rd, alu_op, alu_src_b, funct3, result_src,
//   reg_write, mem_write, branch, jump, jalr - decoded ID/EX fields
//   fwd_a_sel, fwd_b_sel  - bypass selects for rs1 / rs2
//   mem_alu_result, wb_result - bypass sources
//   flush_e               - squash the instruction in EX
//   EX_to_MEM             - EX/MEM register bundle (registered)
//   MemWriteM, WriteDataM, PCPlus4M - registered alongside EX_to_MEM
//   pc_src, pc_target, ex_busy      - combinational redirect / stall outputs
// -----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  addr_t               pc,
  input  data_t               rs1_data,
  input  data_t               rs2_data,
  input  data_t               imm,
  input  logic [4:0]          rd,
  input  alu_op_t             alu_op,
  input  logic                alu_src_b,
  input  logic [2:0]          funct3,
  input  logic [1:0]          result_src,
  input  logic                reg_write,
  input  logic                mem_write,
  input  logic                branch,
  input  logic                jump,
  input  logic                jalr,
  input  logic [1:0]          fwd_a_sel,
  input  logic [1:0]          fwd_b_sel,
  input  data_t               mem_alu_result,
  input  data_t               wb_result,
  input  logic                flush_e,
  ex_to_mem_if.Execute        EX_to_MEM,
  output logic                MemWriteM,
  output data_t               WriteDataM,
  output addr_t               PCPlus4M,
  output logic                pc_src,
  output addr_t               pc_target,
  output logic                ex_busy
);

  data_t rs1Fwd;
  data_t rs2Fwd;
  data_t opB;
  data_t aluOut;
  data_t exResult;
  logic  branchCond;

  // Operand bypass and B-operand source select
  always_comb begin
    rs1Fwd = fwdSelect(fwd_a_sel, rs1_data, wb_result, mem_alu_result);
    rs2Fwd = fwdSelect(fwd_b_sel, rs2_data, wb_result, mem_alu_result);
    if (alu_src_b) begin
      opB = imm;
    end else begin
      opB = rs2Fwd;
    end
  end

  alu u_alu (
    .a      (rs1Fwd),
    .b      (opB),
    .op     (alu_op),
    .result (aluOut)
  );

  // Branch comparison on the forwarded register operands (never on imm)
  always_comb begin
    branchCond = 1'b0;
    case (funct3)
      F3_BEQ:  branchCond = (rs1Fwd == rs2Fwd);
      F3_BNE:  branchCond = (rs1Fwd != rs2Fwd);
      F3_BLT:  branchCond = ($signed(rs1Fwd) <  $signed(rs2Fwd));
      F3_BGE:  branchCond = ($signed(rs1Fwd) >= $signed(rs2Fwd));
      F3_BLTU: branchCond = (rs1Fwd <  rs2Fwd);
      F3_BGEU: branchCond = (rs1Fwd >= rs2Fwd);
      default: branchCond = 1'b0;
    endcase
  end

  // JALR target has bit 0 forced low
  assign pc_target = jalr ? ((rs1Fwd + imm) & 32'hFFFF_FFFE) : (pc + imm);
  assign pc_src    = id_valid & ~flush_e & ~ex_busy & (jump | (branch & branchCond));

`ifdef RV32M_MUL_EN
  mul_state_t mulState;
  mul_state_t mulNext;
  data_t      mulA;
  data_t      mulB;
  data_t      mulLow;
  logic       mulStart;

  // A MUL only starts from IDLE; in BUSY the same (held) instruction completes
  assign mulStart = (mulState == MUL_IDLE) & id_valid & ~flush_e & (alu_op == ALU_MUL);
  assign ex_busy  = mulStart;
  assign mulLow   = mulA * mulB;

  // Multiply FSM next-state
  always_comb begin
    mulNext = mulState;
    case (mulState)
      MUL_IDLE: begin
        if (mulStart) begin
          mulNext = MUL_BUSY;
        end else begin
          mulNext = MUL_IDLE;
        end
      end
      MUL_BUSY: mulNext = MUL_IDLE;
      default:  mulNext = MUL_IDLE;
    endcase
  end

  // Multiply FSM state and captured operands; reset drops any in-flight product
  always_ff @(posedge clk) begin
    if (reset) begin
      mulState <= MUL_IDLE;
      mulA     <= 32'd0;
      mulB     <= 32'd0;
    end else begin
      mulState <= mulNext;
      if (mulStart) begin
        mulA <= rs1Fwd;
        mulB <= opB;
      end else begin
        mulA <= mulA;
        mulB <= mulB;
      end
    end
  end

  assign exResult = (mulState == MUL_BUSY) ? mulLow : aluOut;
`else
  assign ex_busy  = 1'b0;
  assign exResult = aluOut;
`endif

  // EX/MEM register: reset, then flush, then stall bubble, then advance
  always_ff @(posedge clk) begin
    if (reset || flush_e || ex_busy || !id_valid) begin
      EX_to_MEM.RegWrite   <= 1'b0;
      EX_to_MEM.ResultSrc  <= 2'b00;
      EX_to_MEM.rd         <= 5'd0;
      EX_to_MEM.alu_result <= 32'd0;
      EX_to_MEM.funct3     <= 3'b000;
      MemWriteM            <= 1'b0;
      WriteDataM           <= 32'd0;
      PCPlus4M             <= 32'd0;
    end else begin
      EX_to_MEM.RegWrite   <= reg_write;
      EX_to_MEM.ResultSrc  <= result_src;
      EX_to_MEM.rd         <= rd;
      EX_to_MEM.alu_result <= exResult;
      EX_to_MEM.funct3     <= funct3;
      MemWriteM            <= mem_write;
      WriteDataM           <= rs2Fwd;
      PCPlus4M             <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, alu_src_b, reg_write, mem_write, branch, jump, jalr, flush_e;
  addr_t      pc;
  data_t      rs1_data, rs2_data, imm, mem_alu_result, wb_result;
  logic [4:0] rd;
  alu_op_t    alu_op;
  logic [2:0] funct3;
  logic [1:0] result_src, fwd_a_sel, fwd_b_sel;
  logic       memWriteM, pcSrc, exBusy;
  data_t      writeDataM;
  addr_t      pcPlus4M, pcTarget;

  ex_to_mem_if exm();

  execute_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .funct3(funct3),
    .result_src(result_src), .reg_write(reg_write), .mem_write(mem_write),
    .branch(branch), .jump(jump), .jalr(jalr),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_alu_result(mem_alu_result), .wb_result(wb_result),
    .flush_e(flush_e), .EX_to_MEM(exm),
    .MemWriteM(memWriteM), .WriteDataM(writeDataM), .PCPlus4M(pcPlus4M),
    .pc_src(pcSrc), .pc_target(pcTarget), .ex_busy(exBusy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrlBits();
    return {20'd0, exm.RegWrite, exm.ResultSrc, exm.rd, exm.funct3, memWriteM};
  endfunction

  // ---- reference model, straight from the architectural rules ----
  function automatic data_t fwdM(input logic [1:0] s, input data_t r, input data_t w, input data_t m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic data_t aluM(input alu_op_t op, input data_t a, input data_t b);
    longint unsigned sum;
    int sh;
    sh = int'(b % 32'd32);
    case (op)
      ALU_ADD:  begin sum = longint'(a) + longint'(b); return data_t'(sum % 64'h1_0000_0000); end
      ALU_SUB:  begin sum = longint'(a) + 64'h1_0000_0000 - longint'(b); return data_t'(sum % 64'h1_0000_0000); end
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return data_t'((longint'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      ALU_SRL:  return data_t'(longint'(a) / (64'd1 << sh));
      ALU_SRA:  return data_t'($signed(a) >>> sh);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic condM(input logic [2:0] f, input data_t a, input data_t b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return int'(a) < int'(b);
      3'b101:  return int'(a) >= int'(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic setDefaults();
    reset = 1'b0; id_valid = 1'b1; flush_e = 1'b0;
    pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
    mem_alu_result = 32'd0; wb_result = 32'd0; rd = 5'd0;
    alu_op = ALU_ADD; alu_src_b = 1'b0; funct3 = 3'b000; result_src = 2'b00;
    reg_write = 1'b1; mem_write = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
  endtask

  // One non-MUL cycle checked against the model; called at posedge+1
  task automatic step(input string tag);
    data_t a, b2, b, expRes, expTgt;
    logic  expPc, live;
    a      = fwdM(fwd_a_sel, rs1_data, wb_result, mem_alu_result);
    b2     = fwdM(fwd_b_sel, rs2_data, wb_result, mem_alu_result);
    b      = alu_src_b ? imm : b2;
    expRes = aluM(alu_op, a, b);
    expPc  = id_valid & ~flush_e & (jump | (branch & condM(funct3, a, b2)));
    expTgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    live   = ~reset & ~flush_e & id_valid;
    #3;
    chk({tag, ".pc_src"}, {31'd0, pcSrc}, {31'd0, expPc});
    chk({tag, ".pc_target"}, pcTarget, expTgt);
    chk({tag, ".ex_busy"}, {31'd0, exBusy}, 32'd0);
    @(posedge clk); #1;
    if (live) begin
      chk({tag, ".alu_result"}, exm.alu_result, expRes);
      chk({tag, ".ctrl"}, ctrlBits(), {20'd0, reg_write, result_src, rd, funct3, mem_write});
      chk({tag, ".wdata"}, writeDataM, b2);
      chk({tag, ".pc4"}, pcPlus4M, pc + 32'd4);
    end else begin
      chk({tag, ".bubble_res"}, exm.alu_result, 32'd0);
      chk({tag, ".bubble_ctrl"}, ctrlBits(), 32'd0);
      chk({tag, ".bubble_wdata"}, writeDataM, 32'd0);
      chk({tag, ".bubble_pc4"}, pcPlus4M, 32'd0);
    end
  endtask

`ifdef RV32M_MUL_EN
  // MUL: stall cycle with bubble, then product
  task automatic mulSeq(input string tag, input data_t a, input data_t b, input data_t expP);
    setDefaults(); alu_op = ALU_MUL; rs1_data = a; rs2_data = b; rd = 5'd7;
    #3; chk({tag, ".busy1"}, {31'd0, exBusy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, ".bubble"}, ctrlBits(), 32'd0);
    chk({tag, ".bubble_res"}, exm.alu_result, 32'd0);
    #3; chk({tag, ".busy2"}, {31'd0, exBusy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".product"}, exm.alu_result, expP);
    chk({tag, ".regwrite"}, {31'd0, exm.RegWrite}, 32'd1);
  endtask

  // Abort in BUSY with flush (useReset=0) or reset (useReset=1)
  task automatic mulAbort(input string tag, input logic useReset);
    setDefaults(); alu_op = ALU_MUL; rs1_data = 32'd9; rs2_data = 32'd5; rd = 5'd3; mem_write = 1'b1;
    @(posedge clk); #1;             // now in BUSY
    if (useReset) reset = 1'b1; else flush_e = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".ctrl"}, ctrlBits(), 32'd0);
    chk({tag, ".res"}, exm.alu_result, 32'd0);
    reset = 1'b0; flush_e = 1'b0;
    #3; chk({tag, ".idle_again"}, {31'd0, exBusy}, 32'd1);  // busy only rises from IDLE
    @(posedge clk); #1;
    chk({tag, ".no_stale"}, exm.alu_result, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rerun"}, exm.alu_result, 32'd45);
  endtask
`endif

  typedef struct {
    alu_op_t    op;
    addr_t      pc;
    data_t      rs1, rs2, imm, memr;
    logic       srcB;
    logic [1:0] fa;
    logic [2:0] f3;
    logic       br, jp, jr;
    data_t      expRes;
    logic       expPcSrc;
    addr_t      expTarget;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int maxOp;
    vecs[0]  = '{ALU_ADD,  32'h100, 32'hFFFFFFFF, 32'h0,  32'h1,  32'h0,  1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h101};
    vecs[1]  = '{ALU_SUB,  32'h200, 32'hFFFFFFFE, 32'h1,  32'h20, 32'h0,  1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 1'b1, 32'h220};
    vecs[2]  = '{ALU_SUB,  32'h200, 32'hFFFFFFFE, 32'h1,  32'h20, 32'h0,  1'b0, 2'b00, 3'b110, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 1'b0, 32'h220};
    vecs[3]  = '{ALU_SUB,  32'h300, 32'h99,       32'h4,  32'h8,  32'h10, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'hC,        1'b0, 32'h308};
    vecs[4]  = '{ALU_ADD,  32'h400, 32'h1001,     32'h0,  32'h0,  32'h0,  1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1001,     1'b1, 32'h1000};
    vecs[5]  = '{ALU_SRA,  32'h500, 32'h80000000, 32'h0,  32'h4,  32'h0,  1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hF8000000, 1'b0, 32'h504};
    vecs[6]  = '{ALU_SLL,  32'h600, 32'h1,        32'd31, 32'h0,  32'h0,  1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 32'h600};
    vecs[7]  = '{ALU_XOR,  32'h700, 32'h5,        32'h5,  32'h10, 32'h0,  1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h710};
    vecs[8]  = '{ALU_XOR,  32'h700, 32'h5,        32'h5,  32'h10, 32'h0,  1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h710};
    vecs[9]  = '{ALU_SLT,  32'h0,   32'hFFFFFFFF, 32'h1,  32'h0,  32'h0,  1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1,        1'b0, 32'h0};
    vecs[10] = '{ALU_SLTU, 32'h0,   32'hFFFFFFFF, 32'h1,  32'h0,  32'h0,  1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{ALU_OR,   32'h800, 32'hFFFFFFFF, 32'h1,  32'hC,  32'h0,  1'b0, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h80C};
    vecs[12] = '{ALU_OR,   32'h800, 32'hFFFFFFFF, 32'h1,  32'hC,  32'h0,  1'b0, 2'b00, 3'b111, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h80C};
    vecs[13] = '{ALU_SRL,  32'h900, 32'h80000000, 32'h0,  32'h1F, 32'h0,  1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1,        1'b0, 32'h91F};
    vecs[14] = '{ALU_AND,  32'h0,   32'hF0F0,     32'hFF00, 32'h0, 32'h0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hF000,     1'b0, 32'h0};

    setDefaults();
    reset = 1'b1;
    @(posedge clk); #1;
    step("reset");
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      setDefaults();
      alu_op = vecs[i].op; pc = vecs[i].pc; rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
      imm = vecs[i].imm; mem_alu_result = vecs[i].memr; alu_src_b = vecs[i].srcB;
      fwd_a_sel = vecs[i].fa; funct3 = vecs[i].f3; branch = vecs[i].br; jump = vecs[i].jp;
      jalr = vecs[i].jr; rd = 5'(i + 1);
      #3;
      chk($sformatf("vec%0d.pc_src", i), {31'd0, pcSrc}, {31'd0, vecs[i].expPcSrc});
      chk($sformatf("vec%0d.pc_target", i), pcTarget, vecs[i].expTarget);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.alu_result", i), exm.alu_result, vecs[i].expRes);
      chk($sformatf("vec%0d.regwrite", i), {31'd0, exm.RegWrite}, 32'd1);
      chk($sformatf("vec%0d.pc4", i), pcPlus4M, vecs[i].pc + 32'd4);
    end

    // Flush beats an advancing jump
    setDefaults(); jump = 1'b1; rs1_data = 32'd3; imm = 32'd5; mem_write = 1'b1; flush_e = 1'b1;
    step("flush_jump");
    // Invalid instruction becomes a bubble
    setDefaults(); id_valid = 1'b0; jump = 1'b1; mem_write = 1'b1; rs1_data = 32'd1;
    step("invalid");
    // Forward from WB on both operands
    setDefaults(); fwd_a_sel = 2'b01; fwd_b_sel = 2'b01; wb_result = 32'h21; rs1_data = 32'h7; mem_write = 1'b1;
    step("fwd_wb");

`ifdef RV32M_MUL_EN
    mulSeq("mul_big", 32'h10000, 32'h10000, 32'h0);
    mulSeq("mul_7x6", 32'd7, 32'd6, 32'd42);
    mulAbort("mul_flush", 1'b0);
    mulAbort("mul_reset", 1'b1);
    maxOp = 9;
`else
    setDefaults(); alu_op = ALU_MUL; rs1_data = 32'd7; rs2_data = 32'd6; rd = 5'd4;
    step("mul_off");
    maxOp = 10;
`endif

    // Randomized cycles against the model
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 31) == 0);
      id_valid   = ($urandom_range(0, 7) != 0);
      flush_e    = ($urandom_range(0, 7) == 0);
      alu_op     = alu_op_t'(4'($urandom_range(0, maxOp)));
      pc         = $urandom; rs1_data = $urandom; imm = $urandom;
      rs2_data   = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      mem_alu_result = $urandom; wb_result = $urandom;
      fwd_a_sel  = 2'($urandom_range(0, 3)); fwd_b_sel = 2'($urandom_range(0, 3));
      alu_src_b  = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
      jump       = ($urandom_range(0, 3) == 0); jalr = 1'($urandom_range(0, 1));
      funct3     = 3'($urandom_range(0, 7)); result_src = 2'($urandom_range(0, 3));
      rd         = 5'($urandom_range(0, 31)); reg_write = 1'($urandom_range(0, 1));
      mem_write  = 1'($urandom_range(0, 1));
      step($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
